// File: rtl/decoder_nto2n_seq_if.sv
// Purpose : control and decoded-output bundle for decoder_nto2n_seq.
// Latency : n/a (signal bundle only).
// Backpr. : none; the decoder accepts a control word every clock.
// Ports   : en, mode, sel, load (controller -> decoder); D, idx, valid, wrap (decoder -> consumer).
interface decoder_nto2n_seq_if #(
    parameter int SEL_W = 3
);
    logic                  en;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic                  load;
    logic [2**SEL_W-1:0]   D;
    logic [SEL_W-1:0]      idx;
    logic                  valid;
    logic                  wrap;

    modport master (
        output en, mode, sel, load,
        input  D, idx, valid, wrap
    );

    modport slave (
        input  en, mode, sel, load,
        output D, idx, valid, wrap
    );
endinterface

// File: rtl/decoder_nto2n_seq.sv
// Purpose : registered SEL_W:2**SEL_W one-hot decoder, DIRECT (external select) or SCAN (auto-step, DWELL clocks each).
// Latency : 1 clock from en/mode/sel/load to D/idx/valid/wrap; no combinational input-to-output path.
// Backpr. : none; a new control word is taken every clock.
// Ports   : clk, rst (async active-high); bus.slave carries en/mode/sel/load in, D/idx/valid/wrap out.
module decoder_nto2n_seq #(
    parameter int SEL_W      = 3,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    decoder_nto2n_seq_if.slave   bus
);
    localparam int N     = 2**SEL_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [N-1:0]     D_OFF    = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    logic [N-1:0]      d_q;
    logic [SEL_W-1:0]  idx_q;
    logic              valid_q;
    logic              wrap_q;
    logic [CNT_W-1:0]  cnt;
    logic              mode_q;
    logic              en_q;

    logic [SEL_W-1:0]  scan_idx;
    logic [CNT_W-1:0]  scan_cnt;
    logic              scan_wrap;

    function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] i);
        logic [N-1:0] hot;
        hot = N'(1) << i;
        return (ACTIVE_LOW != 0) ? ~hot : hot;
    endfunction

    // Next SCAN position. A load wins outright; entering SCAN (from DIRECT or
    // from disabled) restarts the dwell on the retained idx so a full DWELL
    // is shown before the first step.
    always_comb begin
        scan_idx  = idx_q;
        scan_cnt  = cnt + 1'b1;
        scan_wrap = 1'b0;
        if (bus.load) begin
            scan_idx = bus.sel;
            scan_cnt = '0;
        end else if (!mode_q || !en_q) begin
            scan_cnt = '0;
        end else if (cnt == CNT_LAST) begin
            scan_idx  = idx_q + 1'b1;
            scan_cnt  = '0;
            scan_wrap = (idx_q == {SEL_W{1'b1}});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q     <= D_OFF;
            idx_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            cnt     <= '0;
            mode_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            mode_q <= bus.mode;
            en_q   <= bus.en;
            if (!bus.en) begin
                // idx holds so a later re-enable in SCAN resumes where it stopped
                d_q     <= D_OFF;
                valid_q <= 1'b0;
                wrap_q  <= 1'b0;
                cnt     <= '0;
            end else if (!bus.mode) begin
                idx_q   <= bus.sel;
                d_q     <= decode(bus.sel);
                valid_q <= 1'b1;
                wrap_q  <= 1'b0;
                cnt     <= '0;
            end else begin
                idx_q   <= scan_idx;
                d_q     <= decode(scan_idx);
                valid_q <= 1'b1;
                wrap_q  <= scan_wrap;
                cnt     <= scan_cnt;
            end
        end
    end

    assign bus.D     = d_q;
    assign bus.idx   = idx_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Purpose : self-checking bench for decoder_nto2n_seq, two configurations side by side.
// Latency : n/a.
// Backpr. : n/a.
module tb_decoder_nto2n_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decoder_nto2n_seq_if #(.SEL_W(3)) if0 ();
    decoder_nto2n_seq_if #(.SEL_W(4)) if1 ();

    decoder_nto2n_seq #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0)
    );
    decoder_nto2n_seq #(.SEL_W(4), .DWELL(1), .ACTIVE_LOW(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference model: current position, clocks spent at that position, and
    // what was applied on the previous edge (to spot entry into SCAN).
    function automatic int nsz(input int k);   return (k != 0) ? 16 : 8; endfunction
    function automatic int dwell(input int k); return (k != 0) ? 1 : 4;  endfunction
    function automatic bit alow(input int k);  return k != 0;            endfunction

    int m_idx   [2];
    int m_age   [2];
    bit m_valid [2];
    bit m_wrap  [2];
    bit m_pen   [2];
    bit m_pmode [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_idx[k] = 0; m_age[k] = 0; m_valid[k] = 0;
                m_wrap[k] = 0; m_pen[k] = 0; m_pmode[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit e, md, ld;
                int s;
                e  = (k != 0) ? if1.en   : if0.en;
                md = (k != 0) ? if1.mode : if0.mode;
                ld = (k != 0) ? if1.load : if0.load;
                s  = (k != 0) ? int'(if1.sel) : int'(if0.sel);
                m_wrap[k] = 0;
                if (!e) begin
                    m_valid[k] = 0;
                    m_age[k]   = 0;
                end else if (!md) begin
                    m_idx[k]   = s;
                    m_valid[k] = 1;
                    m_age[k]   = 0;
                end else begin
                    m_valid[k] = 1;
                    if (ld) begin
                        m_idx[k] = s;
                        m_age[k] = 0;
                    end else if (!m_pmode[k] || !m_pen[k]) begin
                        m_age[k] = 0;
                    end else if (m_age[k] + 1 >= dwell(k)) begin
                        m_wrap[k] = (m_idx[k] == nsz(k) - 1);
                        m_idx[k]  = (m_idx[k] + 1) % nsz(k);
                        m_age[k]  = 0;
                    end else begin
                        m_age[k] = m_age[k] + 1;
                    end
                end
                m_pen[k]   = e;
                m_pmode[k] = md;
            end
        end
    end

    function automatic logic [63:0] exp_d(input int k);
        logic [63:0] hot, mask;
        mask = (64'(1) << nsz(k)) - 64'(1);
        hot  = m_valid[k] ? (64'(1) << m_idx[k]) : 64'(0);
        return alow(k) ? (~hot & mask) : hot;
    endfunction

    always @(negedge clk) begin
        chk("m_d0",     64'(if0.D),     exp_d(0));
        chk("m_idx0",   64'(if0.idx),   64'(m_idx[0]));
        chk("m_valid0", 64'(if0.valid), 64'(m_valid[0]));
        chk("m_wrap0",  64'(if0.wrap),  64'(m_wrap[0]));
        chk("m_d1",     64'(if1.D),     exp_d(1));
        chk("m_idx1",   64'(if1.idx),   64'(m_idx[1]));
        chk("m_valid1", 64'(if1.valid), 64'(m_valid[1]));
        chk("m_wrap1",  64'(if1.wrap),  64'(m_wrap[1]));
    end

    initial begin
        logic [15:0] e16;
        if0.en = 0; if0.mode = 0; if0.load = 0; if0.sel = '0;
        if1.en = 0; if1.mode = 0; if1.load = 0; if1.sel = '0;
        #1 rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;

        // get both scanning, then reset mid-scan
        if0.en = 1; if0.mode = 1; if1.en = 1; if1.mode = 1;
        repeat (11) @(negedge clk);
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("t1_d0",     64'(if0.D),     64'h00);
        chk("t1_idx0",   64'(if0.idx),   64'd0);
        chk("t1_valid0", 64'(if0.valid), 64'd0);
        chk("t1_wrap0",  64'(if0.wrap),  64'd0);
        chk("t1_d1",     64'(if1.D),     64'hFFFF);
        chk("t1_idx1",   64'(if1.idx),   64'd0);
        @(negedge clk);
        rst = 0;

        // DIRECT
        if0.mode = 0; if0.sel = 3'd5;
        @(negedge clk);
        chk("t2_d",     64'(if0.D),     64'b00100000);
        chk("t2_idx",   64'(if0.idx),   64'd5);
        chk("t2_valid", 64'(if0.valid), 64'd1);
        for (int i = 0; i < 8; i++) begin
            if0.sel = 3'(i);
            @(negedge clk);
            chk("t2_sweep", 64'(if0.D), 64'(1) << i);
        end

        // SCAN with load at 6, dwell 4, wrap on 7 -> 0
        if0.mode = 1;
        @(negedge clk);
        if0.load = 1; if0.sel = 3'd6;
        @(negedge clk);
        if0.load = 0;
        for (int j = 0; j < 4; j++) begin
            chk("t3_d6", 64'(if0.D), 64'b01000000);
            chk("t3_w6", 64'(if0.wrap), 64'd0);
            @(negedge clk);
        end
        for (int j = 0; j < 4; j++) begin
            chk("t3_d7", 64'(if0.D), 64'b10000000);
            chk("t3_w7", 64'(if0.wrap), 64'd0);
            @(negedge clk);
        end
        chk("t3_d0",    64'(if0.D),    64'b00000001);
        chk("t3_wrap",  64'(if0.wrap), 64'd1);
        @(negedge clk);
        chk("t3_wrap1", 64'(if0.wrap), 64'd0);

        // load on the edge where the dwell would have expired
        repeat (2) @(negedge clk);
        if0.load = 1; if0.sel = 3'd2;
        @(negedge clk);
        if0.load = 0;
        for (int j = 0; j < 4; j++) begin
            chk("t4_d2", 64'(if0.D), 64'b00000100);
            @(negedge clk);
        end
        chk("t4_d3", 64'(if0.D), 64'b00001000);

        // disable mid-dwell at idx 3, re-enable, then back to DIRECT
        @(negedge clk);
        if0.en = 0;
        @(negedge clk);
        chk("t5_off_d",     64'(if0.D),     64'd0);
        chk("t5_off_valid", 64'(if0.valid), 64'd0);
        chk("t5_off_idx",   64'(if0.idx),   64'd3);
        if0.en = 1;
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            chk("t5_on_d3", 64'(if0.D), 64'b00001000);
            @(negedge clk);
        end
        chk("t5_on_d4", 64'(if0.D), 64'b00010000);
        if0.mode = 0; if0.sel = 3'd7;
        @(negedge clk);
        chk("t5_dir_d",    64'(if0.D),    64'b10000000);
        chk("t5_dir_wrap", 64'(if0.wrap), 64'd0);

        // active-low, 16 outputs, step every clock
        if1.load = 1; if1.sel = 4'd0;
        @(negedge clk);
        if1.load = 0;
        for (int i = 0; i <= 16; i++) begin
            e16 = ~(16'(1) << (i % 16));
            chk("t6_d",    64'(if1.D),    64'(e16));
            chk("t6_wrap", 64'(if1.wrap), 64'(i == 16));
            @(negedge clk);
        end

        // randomized traffic on both against the model
        for (int c = 0; c < 800; c++) begin
            bit ne, nm;
            ne = ($urandom_range(0, 9) != 0);
            nm = ($urandom_range(0, 15) == 0) ? ~if0.mode : if0.mode;
            if0.load = ne && nm && if0.en && (if0.mode == nm) && ($urandom_range(0, 5) == 0);
            if0.en = ne; if0.mode = nm; if0.sel = 3'($urandom);
            ne = ($urandom_range(0, 9) != 0);
            nm = ($urandom_range(0, 15) == 0) ? ~if1.mode : if1.mode;
            if1.load = ne && nm && if1.en && (if1.mode == nm) && ($urandom_range(0, 5) == 0);
            if1.en = ne; if1.mode = nm; if1.sel = 4'($urandom);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
